passcode_lock: RTL and testbench

Parametrised passcode entry/verify engine, the successor to the 4-digit fixed password manager. It adds:
- configurable digit count and radix;
- a failed-attempt counter with timed lockout;
- a timed result display;
- an abort path.

It sits behind the board's synchronizer/debouncer/edge-detect front end, so all command inputs are single-cycle pulses. Its outputs feed the SSD mux, LEDs and VGA status.

---
 rtl/passcode_lock.sv | 275 +++++++++++++++++++++++++++
 tb/tb_passcode_lock.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/passcode_lock.sv
// ---------------------------------------------------------------------------
// passcode_lock
//
// Passcode entry and verify engine. The user programs a code of DIGITS
// digits (each 0..MAX_VAL) and can later key in a candidate for checking.
// A matching check shows pass for HOLD_CYCLES cycles. A mismatching check
// shows fail for HOLD_CYCLES cycles. After MAX_TRIES consecutive mismatches
// the lock enters LOCKOUT for LOCK_CYCLES cycles. The stored code never
// leaves this module; digits_out only shows the entry buffer being edited.
//
// All command inputs are single-cycle pulses from the debounce/edge-detect
// front end. Every output is a register, so a pulse sampled at edge N
// becomes visible right after edge N.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   set_req     pulse: start programming a new code (IDLE only)
//   enter_req   pulse: start keying a code for checking (IDLE, code stored)
//   abort       pulse: leave SET/ENTER without effect
//   next        pulse: move the cursor to the next digit (wraps)
//   up          pulse: increment the digit at the cursor (wraps)
//   down        pulse: decrement the digit at the cursor (wraps)
//   commit      pulse: store the code (SET) or check it (ENTER)
//   digits_out  entry buffer, digit 0 in the LSBs
//   cursor      index of the selected digit
//   state       0 IDLE, 1 SET, 2 ENTER, 3 RESULT, 4 LOCKOUT
//   code_valid  a code has been stored since reset
//   pass        high throughout RESULT after a matching check
//   fail        high throughout RESULT/LOCKOUT after a mismatching check
//   locked      high in LOCKOUT
//   tries_left  checks remaining before lockout
// ---------------------------------------------------------------------------
module passcode_lock #(
  parameter int DIGITS      = 4,
  parameter int MAX_VAL     = 9,
  parameter int MAX_TRIES   = 3,
  parameter int HOLD_CYCLES = 100000000,
  parameter int LOCK_CYCLES = 500000000,
  localparam int DW  = (MAX_VAL > 0) ? $clog2(MAX_VAL + 1) : 1,
  localparam int CW  = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int TRW = $clog2(MAX_TRIES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_req,
  input  logic                 enter_req,
  input  logic                 abort,
  input  logic                 next,
  input  logic                 up,
  input  logic                 down,
  input  logic                 commit,
  output logic [DIGITS*DW-1:0] digits_out,
  output logic [CW-1:0]        cursor,
  output logic [2:0]           state,
  output logic                 code_valid,
  output logic                 pass,
  output logic                 fail,
  output logic                 locked,
  output logic [TRW-1:0]       tries_left
);

  // State encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SET     = 3'd1;
  localparam logic [2:0] ST_ENTER   = 3'd2;
  localparam logic [2:0] ST_RESULT  = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  // The single dwell timer serves both RESULT and LOCKOUT. It counts down
  // from the dwell length minus one, so it must hold the larger of the two.
  localparam int TMAX = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]  HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]  LOCK_LOAD  = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0]  TIMER_ONE  = TW'(1);
  localparam logic [DW-1:0]  DIGIT_MAX  = DW'(MAX_VAL);
  localparam logic [DW-1:0]  DIGIT_ONE  = DW'(1);
  localparam logic [CW-1:0]  CURSOR_MAX = CW'(DIGITS - 1);
  localparam logic [CW-1:0]  CURSOR_ONE = CW'(1);
  localparam logic [TRW-1:0] TRIES_FULL = TRW'(MAX_TRIES);
  localparam logic [TRW-1:0] TRIES_ONE  = TRW'(1);

  // Registered state
  logic [2:0]                 state_q,      state_d;
  logic [DIGITS-1:0][DW-1:0]  entry_q,      entry_d;
  logic [DIGITS-1:0][DW-1:0]  stored_q,     stored_d;
  logic [CW-1:0]              cursor_q,     cursor_d;
  logic                       code_valid_q, code_valid_d;
  logic                       pass_q,       pass_d;
  logic                       fail_q,       fail_d;
  logic                       locked_q,     locked_d;
  logic [TRW-1:0]             tries_q,      tries_d;
  logic [TW-1:0]              timer_q,      timer_d;

  // Edit-command arbitration
  logic cmd_abort;
  logic cmd_next;
  logic cmd_up;
  logic cmd_down;
  logic cmd_commit;

  // Datapath helpers
  logic [DW-1:0] cur_digit;
  logic [DW-1:0] digit_inc;
  logic [DW-1:0] digit_dec;
  logic [CW-1:0] cursor_inc;
  logic          code_match;

  // Only one edit command is honoured per cycle. The highest-priority
  // pulse wins and the others in the same cycle are dropped, so that a
  // bounce on two buttons can never apply two edits at once.
  always_comb begin
    cmd_abort  = abort;
    cmd_next   = !abort && next;
    cmd_up     = !abort && !next && up;
    cmd_down   = !abort && !next && !up && down;
    cmd_commit = !abort && !next && !up && !down && commit;
  end

  // Wrap-around arithmetic on the selected digit and the cursor. The
  // digit range 0..MAX_VAL usually does not fill its bit width, so the
  // wraps are explicit compares and not natural overflow.
  always_comb begin
    cur_digit  = entry_q[cursor_q];
    digit_inc  = (cur_digit >= DIGIT_MAX) ? '0 : cur_digit + DIGIT_ONE;
    digit_dec  = (cur_digit == '0) ? DIGIT_MAX : cur_digit - DIGIT_ONE;
    cursor_inc = (cursor_q >= CURSOR_MAX) ? '0 : cursor_q + CURSOR_ONE;
    code_match = (entry_q == stored_q);
  end

  // Next-state logic. Every register gets a hold default first. Each state
  // then overrides only what it changes.
  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    stored_d     = stored_q;
    cursor_d     = cursor_q;
    code_valid_d = code_valid_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    locked_d     = locked_q;
    tries_d      = tries_q;
    timer_d      = timer_q;

    case (state_q)
      ST_IDLE: begin
        if (set_req) begin
          state_d  = ST_SET;
          entry_d  = '0;
          cursor_d = '0;
        end else if (enter_req && code_valid_q) begin
          state_d  = ST_ENTER;
          entry_d  = '0;
          cursor_d = '0;
        end
      end

      ST_SET, ST_ENTER: begin
        if (cmd_abort) begin
          state_d  = ST_IDLE;
          entry_d  = '0;
          cursor_d = '0;
        end else if (cmd_next) begin
          cursor_d = cursor_inc;
        end else if (cmd_up) begin
          entry_d[cursor_q] = digit_inc;
        end else if (cmd_down) begin
          entry_d[cursor_q] = digit_dec;
        end else if (cmd_commit) begin
          entry_d  = '0;
          cursor_d = '0;
          if (state_q == ST_SET) begin
            // A newly programmed code also forgives earlier failures.
            stored_d     = entry_q;
            code_valid_d = 1'b1;
            tries_d      = TRIES_FULL;
            state_d      = ST_IDLE;
          end else if (code_match) begin
            pass_d  = 1'b1;
            tries_d = TRIES_FULL;
            timer_d = HOLD_LOAD;
            state_d = ST_RESULT;
          end else if (tries_q > TRIES_ONE) begin
            fail_d  = 1'b1;
            tries_d = tries_q - TRIES_ONE;
            timer_d = HOLD_LOAD;
            state_d = ST_RESULT;
          end else begin
            // This mismatch uses up the last try.
            fail_d   = 1'b1;
            locked_d = 1'b1;
            tries_d  = '0;
            timer_d  = LOCK_LOAD;
            state_d  = ST_LOCKOUT;
          end
        end
      end

      ST_RESULT: begin
        // The exit happens in the cycle the timer already reads zero. With
        // a load of HOLD_CYCLES-1, the dwell is exactly HOLD_CYCLES.
        if (timer_q == '0) begin
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end

      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          fail_d   = 1'b0;
          locked_d = 1'b0;
          tries_d  = TRIES_FULL;
          state_d  = ST_IDLE;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end

      default: begin
        // Recovery from a corrupted state register. The stored code and
        // the failure count stay as they are. Transient indications are
        // dropped.
        state_d  = ST_IDLE;
        entry_d  = '0;
        cursor_d = '0;
        pass_d   = 1'b0;
        fail_d   = 1'b0;
        locked_d = 1'b0;
        timer_d  = '0;
      end
    endcase
  end

  // State register. The reset clears everything, including the stored code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      entry_q      <= '0;
      stored_q     <= '0;
      cursor_q     <= '0;
      code_valid_q <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      locked_q     <= 1'b0;
      tries_q      <= TRIES_FULL;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      stored_q     <= stored_d;
      cursor_q     <= cursor_d;
      code_valid_q <= code_valid_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      locked_q     <= locked_d;
      tries_q      <= tries_d;
      timer_q      <= timer_d;
    end
  end

  assign digits_out = entry_q;
  assign cursor     = cursor_q;
  assign state      = state_q;
  assign code_valid = code_valid_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign locked     = locked_q;
  assign tries_left = tries_q;

endmodule

// File: tb/tb_passcode_lock.sv
// ---------------------------------------------------------------------------
// tb_passcode_lock
//
// Directed bench for passcode_lock with DIGITS=4, MAX_VAL=9, MAX_TRIES=3,
// HOLD_CYCLES=4 and LOCK_CYCLES=16. The stimulus pulses commands at
// negedges. For each checked cycle it queues a hand-computed snapshot of
// all outputs, tagged with the cycle number at which that snapshot must
// hold. A monitor samples 2 time units after every posedge. It pops the
// entry for that cycle and compares. Any entry whose cycle went by
// unchecked is reported as missed.
// ---------------------------------------------------------------------------
module tb_passcode_lock;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        set_req = 1'b0;
   logic        enter_req = 1'b0;
   logic        abort = 1'b0;
   logic        next = 1'b0;
   logic        up = 1'b0;
   logic        down = 1'b0;
   logic        commit = 1'b0;
   logic [15:0] digits_out;
   logic [1:0]  cursor;
   logic [2:0]  state;
   logic        code_valid;
   logic        pass;
   logic        fail;
   logic        locked;
   logic [1:0]  tries_left;

   // Pulse bit order: {set_req, enter_req, abort, next, up, down, commit}
   localparam logic [6:0] P_SET    = 7'b1000000;
   localparam logic [6:0] P_ENTER  = 7'b0100000;
   localparam logic [6:0] P_ABORT  = 7'b0010000;
   localparam logic [6:0] P_NEXT   = 7'b0001000;
   localparam logic [6:0] P_UP     = 7'b0000100;
   localparam logic [6:0] P_DOWN   = 7'b0000010;
   localparam logic [6:0] P_COMMIT = 7'b0000001;
   localparam logic [6:0] P_NONE   = 7'b0000000;

   typedef struct packed {
      int           tag;
      logic [127:0] name;
      logic [2:0]   st;
      logic [15:0]  dig;
      logic [1:0]   cur;
      logic         cv;
      logic         p;
      logic         f;
      logic         l;
      logic [1:0]   tl;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   last_tag = 0;
   int   vectors = 0;
   int   miscompares = 0;

   passcode_lock #(
      .DIGITS(4),
      .MAX_VAL(9),
      .MAX_TRIES(3),
      .HOLD_CYCLES(4),
      .LOCK_CYCLES(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .set_req(set_req),
      .enter_req(enter_req),
      .abort(abort),
      .next(next),
      .up(up),
      .down(down),
      .commit(commit),
      .digits_out(digits_out),
      .cursor(cursor),
      .state(state),
      .code_valid(code_valid),
      .pass(pass),
      .fail(fail),
      .locked(locked),
      .tries_left(tries_left)
   );

   always #5 clk = ~clk;

   // Drive one cycle of pulses. The response is due at the coming posedge.
   task applyStimulus(input logic [6:0] pulses);
      @(negedge clk);
      {set_req, enter_req, abort, next, up, down, commit} = pulses;
      last_tag = cyc + 1;
   endtask

   task repeatStimulus(input logic [6:0] pulses, input int n);
      for (int i = 0; i < n; i++) applyStimulus(pulses);
   endtask

   // A short reset pulse that ends well before the next clock edge. Only an
   // asynchronous reset can take effect from it.
   task pulseReset();
      @(negedge clk);
      {set_req, enter_req, abort, next, up, down, commit} = P_NONE;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      last_tag = cyc + 1;
   endtask

   // Queue the expected outputs for the cycle of the most recent stimulus.
   task checkOutput(input logic [127:0] name, input logic [2:0] st,
                    input logic [15:0] dig, input logic [1:0] cur,
                    input logic cv, input logic p, input logic f,
                    input logic l, input logic [1:0] tl);
      exp_t e;
      e.tag  = last_tag;
      e.name = name;
      e.st   = st;
      e.dig  = dig;
      e.cur  = cur;
      e.cv   = cv;
      e.p    = p;
      e.f    = f;
      e.l    = l;
      e.tl   = tl;
      sb.push_back(e);
   endtask

   // Monitor: compare the DUT outputs with the queued expectation for this cycle.
   always @(posedge clk) begin : monitor
      exp_t        e;
      logic [27:0] act;
      logic [27:0] req;
      cyc = cyc + 1;
      #2;
      while (sb.size() > 0 && sb[0].tag < cyc) begin
         e = sb.pop_front();
         vectors++;
         miscompares++;
         $display("[TB] FAIL %0s: check for cycle %0d was never reached", e.name, e.tag);
      end
      if (sb.size() > 0 && sb[0].tag == cyc) begin
         e = sb.pop_front();
         act = {state, digits_out, cursor, code_valid, pass, fail, locked, tries_left};
         req = {e.st, e.dig, e.cur, e.cv, e.p, e.f, e.l, e.tl};
         vectors++;
         if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %0s @cycle %0d: got st=%0d dig=%h cur=%0d cv=%b p=%b f=%b l=%b tl=%0d, expected st=%0d dig=%h cur=%0d cv=%b p=%b f=%b l=%b tl=%0d",
                     e.name, cyc, state, digits_out, cursor, code_valid, pass, fail, locked, tries_left,
                     e.st, e.dig, e.cur, e.cv, e.p, e.f, e.l, e.tl);
         end
      end
   end

   // Directed scenarios from the test plan, followed by the final summary.
   initial begin
      // 1: reset values, and enter_req with no stored code is ignored
      applyStimulus(P_NONE);
      checkOutput("reset", 3'd0, 16'h0000, 2'd0, 0, 0, 0, 0, 2'd3);
      applyStimulus(P_NONE);
      checkOutput("reset_hold", 3'd0, 16'h0000, 2'd0, 0, 0, 0, 0, 2'd3);
      rst = 1'b0;
      applyStimulus(P_ENTER);
      checkOutput("enter_no_code", 3'd0, 16'h0000, 2'd0, 0, 0, 0, 0, 2'd3);

      // 2: program code 0,2,9,3 (digit3..0)
      applyStimulus(P_SET);
      checkOutput("set_start", 3'd1, 16'h0000, 2'd0, 0, 0, 0, 0, 2'd3);
      repeatStimulus(P_UP, 3);
      checkOutput("set_d0_up3", 3'd1, 16'h0003, 2'd0, 0, 0, 0, 0, 2'd3);
      applyStimulus(P_NEXT);
      checkOutput("set_next", 3'd1, 16'h0003, 2'd1, 0, 0, 0, 0, 2'd3);
      applyStimulus(P_DOWN);
      checkOutput("set_d1_wrap", 3'd1, 16'h0093, 2'd1, 0, 0, 0, 0, 2'd3);
      applyStimulus(P_NEXT);
      repeatStimulus(P_UP, 10);
      checkOutput("set_d2_up10", 3'd1, 16'h0093, 2'd2, 0, 0, 0, 0, 2'd3);
      repeatStimulus(P_UP, 2);
      checkOutput("set_d2_up12", 3'd1, 16'h0293, 2'd2, 0, 0, 0, 0, 2'd3);
      applyStimulus(P_COMMIT);
      checkOutput("set_commit", 3'd0, 16'h0000, 2'd0, 1, 0, 0, 0, 2'd3);

      // 3: matching check, RESULT lasts exactly 4 cycles
      applyStimulus(P_ENTER);
      checkOutput("enter_start", 3'd2, 16'h0000, 2'd0, 1, 0, 0, 0, 2'd3);
      repeatStimulus(P_UP, 3);
      applyStimulus(P_NEXT);
      applyStimulus(P_DOWN);
      applyStimulus(P_NEXT);
      repeatStimulus(P_UP, 2);
      checkOutput("enter_keyed", 3'd2, 16'h0293, 2'd2, 1, 0, 0, 0, 2'd3);
      applyStimulus(P_COMMIT);
      checkOutput("pass_c1", 3'd3, 16'h0000, 2'd0, 1, 1, 0, 0, 2'd3);
      applyStimulus(P_SET);
      checkOutput("pass_c2_set_ign", 3'd3, 16'h0000, 2'd0, 1, 1, 0, 0, 2'd3);
      applyStimulus(P_NONE);
      checkOutput("pass_c3", 3'd3, 16'h0000, 2'd0, 1, 1, 0, 0, 2'd3);
      applyStimulus(P_NONE);
      checkOutput("pass_c4", 3'd3, 16'h0000, 2'd0, 1, 1, 0, 0, 2'd3);
      applyStimulus(P_NONE);
      checkOutput("pass_done", 3'd0, 16'h0000, 2'd0, 1, 0, 0, 0, 2'd3);

      // 4: three wrong checks lead to lockout
      applyStimulus(P_ENTER);
      applyStimulus(P_COMMIT);
      checkOutput("fail1", 3'd3, 16'h0000, 2'd0, 1, 0, 1, 0, 2'd2);
      repeatStimulus(P_NONE, 3);
      checkOutput("fail1_c4", 3'd3, 16'h0000, 2'd0, 1, 0, 1, 0, 2'd2);
      applyStimulus(P_NONE);
      checkOutput("fail1_done", 3'd0, 16'h0000, 2'd0, 1, 0, 0, 0, 2'd2);
      applyStimulus(P_ENTER);
      applyStimulus(P_COMMIT);
      checkOutput("fail2", 3'd3, 16'h0000, 2'd0, 1, 0, 1, 0, 2'd1);
      repeatStimulus(P_NONE, 4);
      checkOutput("fail2_done", 3'd0, 16'h0000, 2'd0, 1, 0, 0, 0, 2'd1);
      applyStimulus(P_ENTER);
      checkOutput("enter3", 3'd2, 16'h0000, 2'd0, 1, 0, 0, 0, 2'd1);
      applyStimulus(P_COMMIT);
      checkOutput("lockout", 3'd4, 16'h0000, 2'd0, 1, 0, 1, 1, 2'd0);
      applyStimulus(P_SET);
      checkOutput("lock_set_ign", 3'd4, 16'h0000, 2'd0, 1, 0, 1, 1, 2'd0);
      applyStimulus(P_ENTER);
      checkOutput("lock_enter_ign", 3'd4, 16'h0000, 2'd0, 1, 0, 1, 1, 2'd0);
      repeatStimulus(P_NONE, 13);
      checkOutput("lock_c16", 3'd4, 16'h0000, 2'd0, 1, 0, 1, 1, 2'd0);
      applyStimulus(P_NONE);
      checkOutput("lock_done", 3'd0, 16'h0000, 2'd0, 1, 0, 0, 0, 2'd3);

      // 5: simultaneous pulses and cursor wrap
      applyStimulus(P_SET | P_ENTER);
      checkOutput("set_over_enter", 3'd1, 16'h0000, 2'd0, 1, 0, 0, 0, 2'd3);
      applyStimulus(P_ABORT);
      checkOutput("set_abort", 3'd0, 16'h0000, 2'd0, 1, 0, 0, 0, 2'd3);
      applyStimulus(P_ENTER);
      checkOutput("enter5", 3'd2, 16'h0000, 2'd0, 1, 0, 0, 0, 2'd3);
      applyStimulus(P_NEXT | P_UP);
      checkOutput("next_over_up", 3'd2, 16'h0000, 2'd1, 1, 0, 0, 0, 2'd3);
      repeatStimulus(P_NEXT, 2);
      checkOutput("cursor3", 3'd2, 16'h0000, 2'd3, 1, 0, 0, 0, 2'd3);
      applyStimulus(P_NEXT);
      checkOutput("cursor_wrap", 3'd2, 16'h0000, 2'd0, 1, 0, 0, 0, 2'd3);
      applyStimulus(P_UP | P_DOWN);
      checkOutput("up_over_down", 3'd2, 16'h0001, 2'd0, 1, 0, 0, 0, 2'd3);
      applyStimulus(P_ABORT | P_COMMIT);
      checkOutput("abort_commit", 3'd0, 16'h0000, 2'd0, 1, 0, 0, 0, 2'd3);
      applyStimulus(P_NONE);
      checkOutput("abort_quiet", 3'd0, 16'h0000, 2'd0, 1, 0, 0, 0, 2'd3);

      // 6: asynchronous reset during a partial entry
      applyStimulus(P_ENTER);
      repeatStimulus(P_UP, 2);
      checkOutput("partial", 3'd2, 16'h0002, 2'd0, 1, 0, 0, 0, 2'd3);
      pulseReset();
      checkOutput("async_reset", 3'd0, 16'h0000, 2'd0, 0, 0, 0, 0, 2'd3);
      applyStimulus(P_ENTER);
      checkOutput("post_reset_enter", 3'd0, 16'h0000, 2'd0, 0, 0, 0, 0, 2'd3);
      applyStimulus(P_NONE);
      checkOutput("post_reset_quiet", 3'd0, 16'h0000, 2'd0, 0, 0, 0, 0, 2'd3);

      // The last tag is at most one cycle ahead; give the monitor time to drain.
      repeat (4) @(negedge clk);
      if (sb.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL %0d expectations left unchecked", sb.size());
      end
      if (vectors < 12) begin
         miscompares++;
         $display("[TB] FAIL only %0d vectors checked", vectors);
      end
      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      if (miscompares != 0)
         $display("[TB] TEST FAILED");
      else
         $display("[TB] TEST PASSED");
      $finish;
   end

endmodule
